// File: rtl/board_io_pkg.sv
// Board I/O constants and helpers shared by the input debounce block.
// Timing defaults assume the 50 MHz board oscillator.
package board_io_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned DEBOUNCE_10MS       = CLK_HZ / 100;
    localparam int unsigned REPEAT_DELAY_500MS  = CLK_HZ / 2;
    localparam int unsigned REPEAT_PERIOD_100MS = CLK_HZ / 10;

    // Bits needed to hold any value in 0..max_count, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 32'd2) ? 32'd1 : $clog2(max_count + 32'd1);
    endfunction

endpackage

// File: rtl/board_input_debounce_if.sv
// Pin-side and clean-side signal bundle of the board input debounce block.
// The slave modport is the debouncer; the master modport is the pin driver and consumer.
interface board_input_debounce_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] i_in;
    logic [CHANNELS-1:0] o_level;
    logic [CHANNELS-1:0] o_rise;
    logic [CHANNELS-1:0] o_fall;
    logic [CHANNELS-1:0] o_press;

    modport master (output i_in, input o_level, o_rise, o_fall, o_press);
    modport slave  (input i_in, output o_level, o_rise, o_fall, o_press);
endinterface

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, debounce counter, edge strobes
// and optional press auto-repeat. Every output comes straight from a flop.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter logic        INVERT          = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_press
);

    localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             press_q, press_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             repeating_q, repeating_d;
    logic             s;
    logic             rpt_hit;

    // Synchronise, then accept a new level only after DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        sync1_d = i_pin;
        sync2_d = sync1_q;
        s       = sync2_q ^ INVERT;
        level_d = level_q;
        cnt_d   = '0;
        if (s != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    // Repeat timing runs only while the level is held high and not falling this cycle.
    always_comb begin
        rpt_cnt_d   = '0;
        repeating_d = 1'b0;
        rpt_hit     = 1'b0;
        if (level_q && level_d) begin
            rpt_hit     = (rpt_cnt_q == (repeating_q ? PERIOD_LAST : DELAY_LAST));
            repeating_d = repeating_q | rpt_hit;
            rpt_cnt_d   = rpt_hit ? '0 : rpt_cnt_q + RPT_W'(1);
        end
        press_d = rise_d | (REPEAT_EN & rpt_hit);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q     <= INVERT;
            sync2_q     <= INVERT;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            press_q     <= 1'b0;
            rpt_cnt_q   <= '0;
            repeating_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            press_q     <= press_d;
            rpt_cnt_q   <= rpt_cnt_d;
            repeating_q <= repeating_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_press = press_q;

endmodule

// File: rtl/board_input_debounce.sv
// Debounce and edge-detect all board keys and switches; one independent
// debounce_channel per input pin.
module board_input_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned         CHANNELS        = 4,
    parameter logic [CHANNELS-1:0] INVERT          = '0,
    parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter bit                  REPEAT_EN       = 1'b0,
    parameter int unsigned         REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int unsigned         REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    board_input_debounce_if.slave bus
);

    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;
    logic [CHANNELS-1:0] press_w;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        debounce_channel #(
            .INVERT          (INVERT[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_pin   (bus.i_in[i]),
            .o_level (level_w[i]),
            .o_rise  (rise_w[i]),
            .o_fall  (fall_w[i]),
            .o_press (press_w[i])
        );
    end

    assign bus.o_level = level_w;
    assign bus.o_rise  = rise_w;
    assign bus.o_fall  = fall_w;
    assign bus.o_press = press_w;

endmodule

// File: tb/tb_board_input_debounce.sv
// Bench for board_input_debounce: directed scenarios with literal expectations
// plus random pin activity checked every cycle against a window/timestamp model.
module tb_board_input_debounce;

    localparam int unsigned CH     = 4;
    localparam logic [CH-1:0] INV  = 4'b1111;
    localparam int          D      = 4;
    localparam int          DELAY  = 10;
    localparam int          PERIOD = 3;
    localparam int          MAXE   = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    board_input_debounce_if #(.CHANNELS(CH)) bus ();

    board_input_debounce #(
        .CHANNELS        (CH),
        .INVERT          (INV),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_PERIOD   (PERIOD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Model: s seen at an edge is the pin value two edges earlier (reset-cleared);
    // a level flips when the last D samples since the previous flip/reset all disagree.
    int            edge_n = 0;
    bit            model_valid = 1'b0;
    bit            m_p1 [CH];
    bit            m_p2 [CH];
    bit            s_hist [CH][MAXE];
    int            last_evt [CH];
    int            rise_t [CH];
    logic [CH-1:0] e_level = '0;
    logic [CH-1:0] e_rise  = '0;
    logic [CH-1:0] e_fall  = '0;
    logic [CH-1:0] e_press = '0;
    bit            mv_s;
    bit            mv_ok;
    int            mv_d;

    always @(posedge clk) begin
        for (int c = 0; c < int'(CH); c++) begin
            if (!rst_n) begin
                m_p1[c]     = 1'b0;
                m_p2[c]     = 1'b0;
                e_level[c]  = 1'b0;
                e_rise[c]   = 1'b0;
                e_fall[c]   = 1'b0;
                e_press[c]  = 1'b0;
                last_evt[c] = edge_n;
                rise_t[c]   = edge_n;
            end else begin
                mv_s    = m_p2[c];
                m_p2[c] = m_p1[c];
                m_p1[c] = bus.i_in[c] ^ INV[c];
                s_hist[c][edge_n % MAXE] = mv_s;
                e_rise[c] = 1'b0;
                e_fall[c] = 1'b0;
                mv_ok = (edge_n - last_evt[c] >= D);
                if (mv_ok) begin
                    for (int j = 0; j < D; j++)
                        if (s_hist[c][(edge_n - j) % MAXE] == e_level[c]) mv_ok = 1'b0;
                end
                if (mv_ok) begin
                    e_level[c]  = ~e_level[c];
                    last_evt[c] = edge_n;
                    e_rise[c]   = e_level[c];
                    e_fall[c]   = ~e_level[c];
                    if (e_level[c]) rise_t[c] = edge_n;
                end
                e_press[c] = 1'b0;
                if (e_level[c]) begin
                    mv_d = edge_n - rise_t[c];
                    e_press[c] = (mv_d == 0) || (mv_d >= DELAY && ((mv_d - DELAY) % PERIOD) == 0);
                end
            end
        end
        if (!rst_n) model_valid = 1'b1;
        edge_n++;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_level", bus.o_level, e_level);
            check("model_rise",  bus.o_rise,  e_rise);
            check("model_fall",  bus.o_fall,  e_fall);
            check("model_press", bus.o_press, e_press);
        end
    end

    task automatic check_all_zero(input string name);
        check(name, bus.o_level | bus.o_rise | bus.o_fall | bus.o_press, '0);
    endtask

    int cyc;
    int hold;

    initial begin
        // Reset with every pin at its inactive (high) level.
        bus.i_in = 4'hF;
        rst_n    = 1'b0;
        repeat (3) begin
            step();
            check_all_zero("reset_outputs");
        end
        rst_n = 1'b1;
        repeat (20) begin
            step();
            check_all_zero("idle_after_reset");
        end

        // Clean press on ch0; first sampled at the next edge.
        bus.i_in[0] = 1'b0;
        repeat (5) step();
        check("press_level_early", CH'(bus.o_level[0]), CH'(0));
        step();
        check("press_level", CH'(bus.o_level[0]), CH'(1));
        check("press_rise",  CH'(bus.o_rise[0]),  CH'(1));
        check("press_press", CH'(bus.o_press[0]), CH'(1));

        // Hold ch0 for auto-repeat while ch1 bounces for three cycles.
        for (int j = 1; j <= 21; j++) begin
            step();
            if (j == 1) check("rise_single_cycle", CH'(bus.o_rise[0]), CH'(0));
            check("repeat_press", CH'(bus.o_press[0]),
                  CH'(j == 10 || j == 13 || j == 16 || j == 19));
            check("bounce_quiet", CH'({bus.o_level[1], bus.o_rise[1], bus.o_press[1]}), CH'(0));
            if (j == 2) bus.i_in[1] = 1'b0;
            if (j == 5) bus.i_in[1] = 1'b1;
        end

        // Release ch0.
        bus.i_in[0] = 1'b1;
        for (int m = 1; m <= 9; m++) begin
            step();
            check("release_fall",  CH'(bus.o_fall[0]),  CH'(m == 6));
            check("release_level", CH'(bus.o_level[0]), CH'(m < 6));
            if (m >= 6) check("release_no_press", CH'(bus.o_press[0]), CH'(0));
        end

        // Simultaneous press on ch2 and ch3.
        bus.i_in = 4'b0011;
        for (int m = 1; m <= 7; m++) begin
            step();
            check("simul_rise", bus.o_rise, (m == 6) ? 4'b1100 : 4'b0000);
        end
        bus.i_in = 4'hF;
        repeat (8) step();

        // Press ch2 again and abort it with reset two cycles later.
        bus.i_in = 4'b1011;
        step();
        step();
        rst_n    = 1'b0;
        bus.i_in = 4'b0111;
        repeat (3) begin
            step();
            check_all_zero("reset_abort");
        end

        // Release reset while ch3 is held.
        rst_n = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            step();
            check("held_at_reset_rise", bus.o_rise, (m == 6) ? 4'b1000 : 4'b0000);
        end
        bus.i_in = 4'hF;
        repeat (8) step();

        // Random pin activity with occasional resets; model checks every cycle.
        cyc = 0;
        while (cyc < 3000) begin
            bus.i_in = 4'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            for (int k = 0; k < hold; k++) begin
                step();
                rst_n = 1'b1;
                cyc++;
            end
        end
        rst_n = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
